// File: rtl/gpio_bidir_pio.sv
// rtl/gpio_bidir_pio.sv - Avalon-MM bidirectional GPIO with edge capture and irq
//
// Purpose: WIDTH bidirectional pins with per-bit direction, atomic set/clear
// of output bits, optional open-drain drive, synchronised inputs, edge capture
// with write-1-to-clear and a maskable level interrupt.
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//               4 OUTSET, 5 OUTCLR, 6/7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   readdata    registered read data, upper bits 0
//   bidir_port  pins
//   irq         level interrupt
module gpio_bidir_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int OPEN_DRAIN  = 0,
  parameter int EDGE_TYPE   = 2,
  parameter bit RESET_DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       arm_q, arm_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic             armed;

  wire unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign cur   = sync_q[SYNC_STAGES-1];
  // Edges are ignored until the sync chain and prev register have been
  // refilled from the pins, so reset-zero flops never look like an edge.
  assign armed = (arm_q == 3'(ARM_MAX));

  // Pin drivers
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    if (OPEN_DRAIN != 0) begin : g_od
      assign bidir_port[i] = (dir_q[i] & ~data_out_q[i]) ? 1'b0 : 1'bz;
    end else begin : g_pp
      assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end
  end

  // Input synchroniser and previous-sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bidir_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= cur;
    end
  end

  always_comb begin
    edge_raw = '0;
    if (EDGE_TYPE == 0) begin
      edge_raw = cur & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = ~cur & prev_q;
    end else begin
      edge_raw = cur ^ prev_q;
    end
    edge_det = armed ? edge_raw : '0;
  end

  // Register next-state logic; reads always see pre-write values
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    readdata_d = '0;
    arm_d      = armed ? arm_q : arm_q + 3'd1;

    if (wr_en) begin
      case (address)
        3'd0: data_out_d = wdata;
        3'd1: dir_d      = wdata;
        3'd2: irq_mask_d = wdata;
        3'd3: edge_cap_d = edge_cap_q & ~wdata;
        3'd4: data_out_d = data_out_q | wdata;
        3'd5: data_out_d = data_out_q & ~wdata;
        default: ;
      endcase
    end
    // A new edge wins over a same-cycle clear of the same bit.
    edge_cap_d = edge_cap_d | edge_det;

    case (address)
      3'd0:    readdata_d[WIDTH-1:0] = cur;
      3'd1:    readdata_d[WIDTH-1:0] = dir_q;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4,
      3'd5:    readdata_d[WIDTH-1:0] = data_out_q;
      default: readdata_d = '0;
    endcase

    irq_d = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      dir_q      <= {WIDTH{RESET_DIR}};
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      arm_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      arm_q      <= arm_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bidir_pio.sv
// tb/tb_gpio_bidir_pio.sv - directed self-checking bench for gpio_bidir_pio
module tb_gpio_bidir_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;
  wire  [7:0]  pins_a, pins_b;
  logic [7:0]  ext_a_en, ext_a_val, ext_b_en, ext_b_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    pullup (pins_a[i]);
    pullup (pins_b[i]);
    assign pins_a[i] = ext_a_en[i] ? ext_a_val[i] : 1'bz;
    assign pins_b[i] = ext_b_en[i] ? ext_b_val[i] : 1'bz;
  end

  gpio_bidir_pio #(
    .WIDTH(8), .SYNC_STAGES(2), .OPEN_DRAIN(0), .EDGE_TYPE(1), .RESET_DIR(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .bidir_port(pins_a), .irq(irq_a)
  );

  gpio_bidir_pio #(
    .WIDTH(8), .SYNC_STAGES(2), .OPEN_DRAIN(1), .EDGE_TYPE(2), .RESET_DIR(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .bidir_port(pins_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; ext_a_en = '0; ext_a_val = '0; ext_b_en = '0; ext_b_val = '0;

    // Reset state
    #3;
    chk("rst_readdata_a", readdata_a, 32'h0);
    chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
    chk("rst_pins_a_z", {24'b0, pins_a}, 32'hFF);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Pulled-high pins appear on DATA after 3 clocks
    tick();
    tick();
    chk("sync_e2_a", readdata_a, 32'h0);
    tick();
    chk("sync_e3_a", readdata_a, 32'hFF);
    chk("sync_e3_b", readdata_b, 32'hFF);
    address = 3'd3;
    repeat (6) tick();
    chk("noedge_after_rst_a", readdata_a, 32'h0);
    chk("noedge_after_rst_b", readdata_b, 32'h0);
    chk("noirq_after_rst_a", {31'b0, irq_a}, 32'h0);

    // Direction and drive
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'h05);
    chk("drive_pins_a", {24'b0, pins_a}, 32'hF5);
    chk("drive_pins_b_od", {24'b0, pins_b}, 32'hF5);
    ext_b_en = 8'h01; ext_b_val = 8'h00;
    #1;
    chk("wired_and_pins_b", {24'b0, pins_b}, 32'hF4);
    address = 3'd0;
    repeat (3) tick();
    chk("readback_out_a", readdata_a, 32'hF5);
    chk("readback_wired_and_b", readdata_b, 32'hF4);
    ext_b_en = 8'h00;

    // Atomic set/clear
    wr(3'd0, 32'h30);
    wr(3'd4, 32'h03);
    wr(3'd5, 32'h10);
    address = 3'd4;
    tick();
    chk("outset_outclr_a", readdata_a, 32'h23);
    chk("outset_outclr_b", readdata_b, 32'h23);
    address = 3'd5;
    tick();
    chk("outclr_read_a", readdata_a, 32'h23);
    wr(3'd6, 32'hFF);
    address = 3'd6;
    tick();
    chk("reserved_read_a", readdata_a, 32'h0);
    address = 3'd1;
    tick();
    chk("dir_read_a", readdata_a, 32'h0F);

    // Falling-edge capture and irq timing on pin 2
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h04);
    repeat (5) tick();
    wr(3'd3, 32'hFF);
    address = 3'd3;
    tick();
    chk("ecap_cleared_a", readdata_a, 32'h0);
    chk("irq_cleared_a", {31'b0, irq_a}, 32'h0);
    ext_a_en = 8'h04; ext_a_val = 8'h00;
    tick();
    tick();
    chk("irq_e2_a", {31'b0, irq_a}, 32'h0);
    tick();
    chk("ecap_e3_pre_a", readdata_a, 32'h0);
    chk("irq_e3_a", {31'b0, irq_a}, 32'h0);
    tick();
    chk("ecap_e4_a", readdata_a, 32'h04);
    chk("irq_e4_a", {31'b0, irq_a}, 32'h1);
    wr(3'd3, 32'h04);
    chk("w1c_pre_read_a", readdata_a, 32'h04);
    chk("irq_at_w1c_a", {31'b0, irq_a}, 32'h1);
    tick();
    chk("irq_after_w1c_a", {31'b0, irq_a}, 32'h0);
    chk("ecap_after_w1c_a", readdata_a, 32'h0);

    // Rising edge ignored; edge in same cycle as W1C wins
    ext_a_en = 8'h00;
    repeat (5) tick();
    chk("rise_ignored_a", readdata_a, 32'h0);
    chk("rise_noirq_a", {31'b0, irq_a}, 32'h0);
    ext_a_en = 8'h04;
    tick();
    tick();
    wr(3'd3, 32'h04);
    tick();
    chk("set_wins_ecap_a", readdata_a, 32'h04);
    chk("set_wins_irq_a", {31'b0, irq_a}, 32'h1);
    tick();
    chk("set_wins_irq_hold_a", {31'b0, irq_a}, 32'h1);
    wr(3'd2, 32'h00);
    chk("irq_at_mask_wr_a", {31'b0, irq_a}, 32'h1);
    tick();
    chk("irq_after_mask_clr_a", {31'b0, irq_a}, 32'h0);
    ext_a_en = 8'h00;
    wr(3'd3, 32'hFF);

    // Asynchronous reset mid-operation
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hAA);
    chk("drive_aa_a", {24'b0, pins_a}, 32'hAA);
    chk("drive_aa_b_od", {24'b0, pins_b}, 32'hAA);
    address = 3'd1;
    tick();
    chk("dir_ff_a", readdata_a, 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pins_a", {24'b0, pins_a}, 32'hFF);
    chk("async_rst_pins_b", {24'b0, pins_b}, 32'hFF);
    chk("async_rst_readdata_a", readdata_a, 32'h0);
    chk("async_rst_irq_a", {31'b0, irq_a}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    address = 3'd3;
    repeat (5) tick();
    chk("post_rst_noedge_a", readdata_a, 32'h0);
    chk("post_rst_noedge_b", readdata_b, 32'h0);
    chk("post_rst_noirq_b", {31'b0, irq_b}, 32'h0);
    address = 3'd1;
    tick();
    chk("post_rst_dir_a", readdata_a, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bidir_pio.md
Name: gpio_bidir_pio

Overview:
- Parametrised successor to the single-bit bidirectional I2C line PIO.
- Avalon-MM slave controlling WIDTH bidirectional pins with per-bit direction, atomic set/clear of output bits, optional open-drain drive, synchronised inputs, edge capture and a maskable interrupt.
- Sits between the Qsys/Nios bus and board-level lines: I2C SDA/SCL, camera control, misc GPIO.

Parameters:
- WIDTH, 8, number of pins; legal 1..32.
- SYNC_STAGES, 2, input synchroniser depth; legal 2..4.
- OPEN_DRAIN, 0, 1 = output bit 1 releases the pin to Z; only 0 is ever driven.
- EDGE_TYPE, 2, capture edge: 0 rising, 1 falling, 2 any.
- RESET_DIR, 0, reset value of every direction bit (0 input, 1 output).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- readdata  out  32  registered read data; upper bits 0
- bidir_port  inout  WIDTH  pins
- irq  out  1  level interrupt

Behaviour:
- Reset: clk and reset_n as already decided; reset is asynchronous, active-low on reset_n, clock clk.
- Reset values:
  - data_out = 0
  - dir = all RESET_DIR
  - irq_mask = 0
  - edge_capture = 0
  - readdata = 0
  - sync chain and previous-sample register = 0
  - arm counter = 0
  - irq = 0
- Register map. A write is chipselect & ~write_n at a posedge.
  - addr 0 DATA: read returns synchronised pin value; write loads data_out.
  - addr 1 DIR: read/write, per bit, 1 = output.
  - addr 2 IRQMASK: read/write.
  - addr 3 EDGECAP: read returns edge_capture; write-1-to-clear per bit.
  - addr 4 OUTSET: write ORs writedata into data_out; reads return data_out.
  - addr 5 OUTCLR: write clears data_out bits where writedata=1; reads return data_out.
  - addr 6, 7: writes ignored; reads 0.
- Read latency: readdata is registered every cycle, independent of chipselect, from the address presented that cycle. Valid one cycle later.
- Pin drive per bit i:
  - OPEN_DRAIN=0: drive data_out[i] when dir[i]=1, else Z.
  - OPEN_DRAIN=1: drive 0 when dir[i]=1 and data_out[i]=0, else Z.
- Input path: each pin passes through SYNC_STAGES flops. DATA reads the last stage. In output mode it reads back the pin (wired-AND visible in open-drain).
- Edge detect:
  - Compares the last sync stage with the previous-sample register.
  - Rising = cur & ~prev; falling = ~cur & prev; any = xor.
- Arm counter:
  - Counts from 0 to SYNC_STAGES+1 after reset, then saturates.
  - Edge detection is suppressed until it saturates, so no spurious edge comes from reset-zero sync flops.
- edge_capture[i] sets on a detected edge and holds until cleared.
- Same-cycle edge and W1C on the same bit: set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), registered, so it asserts one cycle after the capture bit sets. Clearing a bit or its mask drops irq one cycle after the write.
- Write and read to the same register in one cycle: readdata shows the pre-write value. The new value is visible on the next read.
- Simultaneous OUTSET/OUTCLR: impossible, single address.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pins go Z if RESET_DIR=0. The arm counter restarts.
- Latency from pin edge to edge_capture set: SYNC_STAGES+1 clocks.

Test Plan:
- Reset, pins pulled high externally, WIDTH=8, SYNC_STAGES=2 -> DATA reads 0xFF after 3 clocks; edge_capture stays 0x00; irq stays 0.
- Write DIR=0x0F, then DATA=0x05 -> bidir_port low nibble = 0101, high nibble Z. With OPEN_DRAIN=1, bits 0 and 2 are Z and bits 1 and 3 are driven 0.
- DATA=0x30, OUTSET 0x03, then OUTCLR 0x10 -> data_out reads back 0x23 via addr 4.
- EDGE_TYPE=1, IRQMASK=0x04, pin 2 falls at cycle t -> edge_capture=0x04 at t+3; irq=1 at t+4. W1C 0x04 -> irq=0 one cycle after the write.
- Pin 2 edge detected in the same cycle as a W1C of 0x04 -> edge_capture bit 2 remains 1; irq remains 1.
- Assert reset_n low mid-transfer while DIR=0xFF, DATA=0xAA -> pins Z and readdata 0 asynchronously; no edge captured within 3 cycles after release.
